// File: rtl/center_integrator.sv
// center_integrator
//   Rebuilds a sample stream x[n] from central-derivative samples
//   d[n] = (x[n+1] - x[n-1]) / 2^HALVED using the recurrence
//   x[n+1] = x[n-1] + (d[n] << HALVED), seeded with x[-1] and x[0].
//   Results are saturated to the OUT_BITS signed range, and the clipped
//   value is what feeds back into the recurrence.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   start      : in IDLE, loads seed_m1/seed_0, clears sat_flag/count_o, goes to RUN
//   clr        : synchronous return to IDLE (drops out_valid); beats start and accept
//   seed_m1    : x[-1], sampled on start
//   seed_0     : x[0], sampled on start
//   IN_der     : signed derivative sample
//   in_valid   : IN_der valid
//   in_ready   : derivative is accepted this cycle when in_valid is also high
//   out_sample : reconstructed x[n+1], registered
//   out_valid  : out_sample valid
//   out_ready  : consumer accepts out_sample
//   sat_flag   : sticky, set when any result was clipped
//   count_o    : number of accepted derivatives (16-bit, wraps)
module center_integrator #(
  parameter int Nbits    = 8,
  parameter int OUT_BITS = 12,
  parameter int HALVED   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       clr,
  input  logic signed [OUT_BITS-1:0] seed_m1,
  input  logic signed [OUT_BITS-1:0] seed_0,
  input  logic signed [Nbits-1:0]    IN_der,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic signed [OUT_BITS-1:0] out_sample,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       sat_flag,
  output logic [15:0]                count_o
);

  localparam logic signed [OUT_BITS-1:0] SAT_MAX = {1'b0, {(OUT_BITS-1){1'b1}}};
  localparam logic signed [OUT_BITS-1:0] SAT_MIN = {1'b1, {(OUT_BITS-1){1'b0}}};

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                       r_state;
  logic signed [OUT_BITS-1:0]   r_x_m1;
  logic signed [OUT_BITS-1:0]   r_x_0;
  logic signed [OUT_BITS-1:0]   r_out;
  logic                         r_out_valid;
  logic                         r_sat;
  logic [15:0]                  r_count;

  logic                         w_in_ready;
  logic                         w_accept;
  logic signed [OUT_BITS:0]     w_der_ext;
  logic signed [OUT_BITS:0]     w_s;
  logic signed [OUT_BITS:0]     w_sum;
  logic signed [OUT_BITS-1:0]   w_res;
  logic                         w_clip;

  // The sum is one bit wider than the result; overflow shows up as the
  // top two bits disagreeing.
  function automatic logic is_clipped(input logic signed [OUT_BITS:0] v);
    return v[OUT_BITS] != v[OUT_BITS-1];
  endfunction

  function automatic logic signed [OUT_BITS-1:0] sat_result(input logic signed [OUT_BITS:0] v);
    if (is_clipped(v)) begin
      return v[OUT_BITS] ? SAT_MIN : SAT_MAX;
    end
    return v[OUT_BITS-1:0];
  endfunction

  // A new derivative can enter when the output register is free or is
  // being drained in the same cycle.
  assign w_in_ready = (r_state == S_RUN) && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;

  // Widen d to OUT_BITS+1 before shifting; with OUT_BITS > Nbits+HALVED
  // the shifted value and the sum both fit without wrapping.
  assign w_der_ext = {{(OUT_BITS+1-Nbits){IN_der[Nbits-1]}}, IN_der};
  assign w_s       = w_der_ext <<< HALVED;
  assign w_sum     = {r_x_m1[OUT_BITS-1], r_x_m1} + w_s;
  assign w_res     = sat_result(w_sum);
  assign w_clip    = is_clipped(w_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_x_m1      <= '0;
      r_x_0       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_sat       <= 1'b0;
      r_count     <= '0;
    end else if (clr) begin
      // Seeds, flag and count are kept so they can still be inspected.
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x_m1  <= seed_m1;
            r_x_0   <= seed_0;
            r_sat   <= 1'b0;
            r_count <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_out       <= w_res;
            r_out_valid <= 1'b1;
            r_x_m1      <= r_x_0;
            r_x_0       <= w_res;
            r_count     <= r_count + 16'd1;
            if (w_clip) begin
              r_sat <= 1'b1;
            end
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = w_in_ready;
  assign out_sample = r_out;
  assign out_valid  = r_out_valid;
  assign sat_flag   = r_sat;
  assign count_o    = r_count;

endmodule

// File: tb/tb_center_integrator.sv
module tb_center_integrator;

  localparam int NB = 8;
  localparam int OB = 12;
  localparam int H  = 1;
  localparam int OMAX = 2047;
  localparam int OMIN = -2048;

  logic clk;
  logic rst_n;
  logic start;
  logic clr;
  logic signed [OB-1:0] seed_m1;
  logic signed [OB-1:0] seed_0;
  logic signed [NB-1:0] IN_der;
  logic in_valid;
  logic out_ready;

  logic                 in_ready1, out_valid1, sat1;
  logic signed [OB-1:0] out1;
  logic [15:0]          cnt1;
  logic                 in_ready0, out_valid0, sat0;
  logic signed [OB-1:0] out0;
  logic [15:0]          cnt0;

  int checks = 0;
  int failures = 0;

  int log1[$];
  int log0[$];

  // Behavioural model state (HALVED=1 instance), plain integers.
  bit m_run = 0;
  int m_xm1 = 0;
  int m_x0  = 0;
  int m_out = 0;
  bit m_ov  = 0;
  bit m_sat = 0;
  int m_cnt = 0;

  center_integrator #(.Nbits(NB), .OUT_BITS(OB), .HALVED(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
    .seed_m1(seed_m1), .seed_0(seed_0), .IN_der(IN_der),
    .in_valid(in_valid), .in_ready(in_ready1),
    .out_sample(out1), .out_valid(out_valid1), .out_ready(out_ready),
    .sat_flag(sat1), .count_o(cnt1)
  );

  center_integrator #(.Nbits(NB), .OUT_BITS(OB), .HALVED(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
    .seed_m1(seed_m1), .seed_0(seed_0), .IN_der(IN_der),
    .in_valid(in_valid), .in_ready(in_ready0),
    .out_sample(out0), .out_valid(out_valid0), .out_ready(out_ready),
    .sat_flag(sat0), .count_o(cnt0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_log(input string name, input int got[$], input int exp[$]);
    chk({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      chk(name, got[i], exp[i]);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > OMAX) return OMAX;
    if (v < OMIN) return OMIN;
    return v;
  endfunction

  function automatic bit clipped(input int v);
    return (v > OMAX) || (v < OMIN);
  endfunction

  function automatic bit model_ready(input bit run, input bit ov, input bit ordy);
    return run && (!ov || ordy);
  endfunction

  // Model: x[n+1] = clamp(x[n-1] + d*2^H), one result register with handshake.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 0; m_xm1 <= 0; m_x0 <= 0; m_out <= 0;
      m_ov <= 0; m_sat <= 0; m_cnt <= 0;
    end else if (clr) begin
      m_run <= 0;
      m_ov  <= 0;
    end else if (!m_run) begin
      if (start) begin
        m_run <= 1;
        m_xm1 <= int'(seed_m1);
        m_x0  <= int'(seed_0);
        m_sat <= 0;
        m_cnt <= 0;
      end
    end else if (in_valid && model_ready(m_run, m_ov, out_ready)) begin
      m_out <= clamp(m_xm1 + int'(IN_der) * (1 << H));
      m_x0  <= clamp(m_xm1 + int'(IN_der) * (1 << H));
      m_xm1 <= m_x0;
      m_ov  <= 1;
      m_cnt <= (m_cnt + 1) % 65536;
      if (clipped(m_xm1 + int'(IN_der) * (1 << H))) m_sat <= 1;
    end else if (out_ready) begin
      m_ov <= 0;
    end
  end

  // Record every completed output transfer of both instances.
  always @(posedge clk) begin
    if (rst_n) begin
      if (out_valid1 && out_ready) log1.push_back(int'(out1));
      if (out_valid0 && out_ready) log0.push_back(int'(out0));
    end
  end

  // Cycle-by-cycle comparison of the HALVED=1 instance against the model.
  always @(negedge clk) begin
    chk("cmp_in_ready", int'(in_ready1), int'(model_ready(m_run, m_ov, out_ready)));
    chk("cmp_out_valid", int'(out_valid1), int'(m_ov));
    if (m_ov) chk("cmp_out_sample", int'(out1), m_out);
    chk("cmp_sat_flag", int'(sat1), int'(m_sat));
    chk("cmp_count", int'(cnt1), m_cnt);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input int sm1, input int s0);
    seed_m1 = OB'(sm1);
    seed_0  = OB'(s0);
    start   = 1;
    step(1);
    start   = 0;
  endtask

  task automatic do_clr();
    clr = 1;
    step(1);
    clr = 0;
  endtask

  initial begin
    int e[$];
    clk = 0; rst_n = 0; start = 0; clr = 0;
    seed_m1 = '0; seed_0 = '0; IN_der = '0; in_valid = 0; out_ready = 0;
    step(2);
    rst_n = 1;
    step(1);

    // Reset state
    chk("rst_out_sample", int'(out1), 0);
    chk("rst_out_valid", int'(out_valid1), 0);
    chk("rst_in_ready", int'(in_ready1), 0);
    chk("rst_count", int'(cnt1), 0);
    chk("rst_sat", int'(sat1), 0);

    // in_valid in IDLE is ignored
    in_valid = 1; IN_der = 8'sd5; out_ready = 1;
    step(2);
    chk("idle_count", int'(cnt1), 0);
    chk("idle_out_valid", int'(out_valid1), 0);
    in_valid = 0;

    // Basic: seeds 0,0, d = 1,1,1,1
    log1.delete(); log0.delete();
    do_start(0, 0);
    in_valid = 1; IN_der = 8'sd1; out_ready = 1;
    step(1);
    chk("lat_valid", int'(out_valid1), 1);
    chk("lat_sample", int'(out1), 2);
    step(3);
    in_valid = 0;
    step(2);
    e = {2, 2, 4, 4};
    chk_log("basic", log1, e);
    e = {1, 1, 2, 2};
    chk_log("basic_h0", log0, e);
    chk("basic_count", int'(cnt1), 4);
    chk("basic_sat", int'(sat1), 0);

    // Negative values: seeds 10,5, d = -3,-7
    do_clr();
    log1.delete(); log0.delete();
    do_start(10, 5);
    in_valid = 1; IN_der = -8'sd3;
    step(1);
    IN_der = -8'sd7;
    step(1);
    in_valid = 0;
    step(2);
    e = {7, -2};
    chk_log("neg_h0", log0, e);
    e = {4, -9};
    chk_log("neg_h1", log1, e);

    // Saturation high, then clipped value feeds back
    do_clr();
    log1.delete(); log0.delete();
    do_start(2040, 2040);
    in_valid = 1; IN_der = 8'sd10;
    step(1);
    chk("sat_hi", int'(out1), 2047);
    chk("sat_flag_set", int'(sat1), 1);
    IN_der = -8'sd100;
    step(1);
    in_valid = 0;
    step(2);
    e = {2047, 1840};
    chk_log("sat_pos", log1, e);
    chk("sat_sticky", int'(sat1), 1);

    // Saturation low
    do_clr();
    do_start(-2040, -2040);
    chk("sat_clr_on_start", int'(sat1), 0);
    in_valid = 1; IN_der = -8'sd10;
    step(1);
    in_valid = 0;
    chk("sat_lo", int'(out1), -2048);
    chk("sat_lo_flag", int'(sat1), 1);
    step(1);

    // Backpressure: stall 3 cycles with a result held
    do_clr();
    log1.delete(); log0.delete();
    do_start(0, 0);
    out_ready = 1; in_valid = 1; IN_der = 8'sd1;
    step(2);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("bp_in_ready", int'(in_ready1), 0);
      chk("bp_hold", int'(out1), 2);
      chk("bp_valid", int'(out_valid1), 1);
    end
    out_ready = 1;
    step(2);
    in_valid = 0;
    step(2);
    e = {2, 2, 4, 4};
    chk_log("bp", log1, e);
    chk("bp_count", int'(cnt1), 4);

    // Control: clr mid-stream, then start together with clr
    do_clr();
    do_start(0, 0);
    in_valid = 1; IN_der = 8'sd1; out_ready = 1;
    step(2);
    clr = 1;
    step(1);
    clr = 0;
    chk("clr_valid", int'(out_valid1), 0);
    chk("clr_ready", int'(in_ready1), 0);
    step(2);
    chk("clr_count_hold", int'(cnt1), 2);
    chk("clr_ignored_valid", int'(out_valid1), 0);
    clr = 1; start = 1;
    step(1);
    clr = 0; start = 0;
    chk("clr_start_ready", int'(in_ready1), 0);
    chk("clr_start_count", int'(cnt1), 2);
    step(1);
    chk("clr_start_valid", int'(out_valid1), 0);
    in_valid = 0;

    // Asynchronous reset mid-RUN with a pending output
    do_start(0, 0);
    in_valid = 1; IN_der = 8'sd1; out_ready = 0;
    step(1);
    chk("pre_rst_valid", int'(out_valid1), 1);
    #2;
    rst_n = 0;
    #1;
    chk("arst_out_valid", int'(out_valid1), 0);
    chk("arst_out_sample", int'(out1), 0);
    chk("arst_count", int'(cnt1), 0);
    chk("arst_in_ready", int'(in_ready1), 0);
    chk("arst_sat", int'(sat1), 0);
    step(1);
    rst_n = 1;
    out_ready = 1;
    step(3);
    chk("post_rst_count", int'(cnt1), 0);
    chk("post_rst_valid", int'(out_valid1), 0);
    do_start(0, 0);
    step(1);
    chk("post_start_count", int'(cnt1), 1);
    chk("post_start_sample", int'(out1), 2);
    in_valid = 0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/center_integrator.md
Name: center_integrator

Overview:
- Inverse of the central-difference stage: rebuilds a sample stream x[n] from central-derivative samples d[n] = (x[n+1] - x[n-1]) / 2^HALVED.
- Recurrence: x[n+1] = x[n-1] + (d[n] << HALVED), seeded with x[-1] and x[0].
- Sits downstream of a derivative stream, for example on the decode/verification side, to reconstruct the original signal.
- Valid/ready handshake on input and output, one registered output stage, saturating arithmetic.

Parameters:
- Nbits, 8, signed width of the derivative input IN_der.
- OUT_BITS, 12, signed width of the reconstructed sample, seeds and accumulators; must be > Nbits + HALVED.
- HALVED, 1, left-shift applied to d before accumulation. 1 = derivative was divided by 2; 0 = raw difference.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  pulse; loads seeds, IDLE->RUN.
- clr  input  1  synchronous clear; any state -> IDLE.
- seed_m1  input  OUT_BITS  signed x[-1], sampled on start.
- seed_0  input  OUT_BITS  signed x[0], sampled on start.
- IN_der  input  Nbits  signed derivative sample.
- in_valid  input  1  IN_der valid.
- in_ready  output  1  block accepts IN_der this cycle.
- out_sample  output  OUT_BITS  signed reconstructed x[n+1].
- out_valid  output  1  out_sample valid.
- out_ready  input  1  consumer accepts out_sample.
- sat_flag  output  1  sticky; set when any result saturated.
- count_o  output  16  number of accepted derivatives, wraps at 65535 -> 0.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; x_m1=0; x_0=0; out_sample=0; out_valid=0; sat_flag=0; count_o=0. in_ready=0 while in reset.
- States:
  - IDLE: in_ready=0. start=1 -> x_m1<=seed_m1, x_0<=seed_0, sat_flag<=0, count_o<=0, next RUN.
  - RUN: in_ready = !out_valid || out_ready (combinational). start is ignored in RUN.
  - clr=1 (any state): next IDLE, out_valid<=0. x_m1, x_0, sat_flag and count_o hold. clr has priority over start and over a simultaneous accept.
- Accept: a derivative is accepted on a rising edge where in_valid && in_ready.
- On accept:
  - s = sign-extend(IN_der) << HALVED, computed at OUT_BITS+1 bits.
  - r = x_m1 + s, saturated to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1].
  - out_sample<=r; out_valid<=1; x_m1<=x_0; x_0<=r; count_o<=count_o+1.
  - sat_flag<=1 if clipping occurred.
- Latency: exactly one cycle from accept to out_valid=1 with the result.
- Throughput: one sample per cycle when out_ready=1.
- Output hold: with out_valid=1 and out_ready=0, out_sample holds stable and in_ready=0. No input is lost or duplicated.
- out_valid clears when out_ready=1 and there is no accept in the same cycle. Simultaneous output drain and new accept keeps out_valid=1 with the new data.
- Saturated results feed back into the recurrence; later samples use the clipped value.
- in_valid while in IDLE: in_ready=0, nothing is accepted, IN_der is ignored.
- Reset mid-RUN: immediate return to reset values. A pending output is dropped.

Test Plan (Nbits=8, OUT_BITS=12, HALVED=1 unless stated):
- Basic: start with seeds 0,0; feed d = 1,1,1,1 with out_ready=1 -> out_sample = 2,2,4,4, each one cycle after accept; count_o=4; sat_flag=0.
- Negative/HALVED=0: seeds 10,5; d = -3, -7 -> outputs 7, -2.
- Saturation: seeds 2040, 2040; d=10 -> out 2047, sat_flag=1. Next d=-100 -> 2040-200 = 1840. Negative seeds -2040,-2040 with d=-10 -> -2048.
- Backpressure: stream d=1 with out_ready held 0 for 3 cycles -> in_ready=0 and out_sample constant during the stall. On release the sequence resumes with no loss or duplication (same values as Basic).
- Control: clr asserted mid-stream -> IDLE, out_valid=0 next cycle, in_valid ignored. start issued together with clr stays in IDLE.
- Reset: deassert rst_n asynchronously mid-RUN with out_valid=1 -> all outputs 0 immediately. After reset, in_valid=1 gets no accept until start.
